uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between several byte-stream printers, such as the table printer, the matrix printer and the error or status printer. Each requester streams ASCII bytes over a valid/ready interface with a last flag. The arbiter grants one requester for a whole packet, using round-robin order between packets. It forwards each byte to the UART with a start/busy handshake and releases the grant on the last byte, when the request drops, or on a timeout.

Parameters:
N_REQ, 3, number of requesters; legal range 2..8.
TIMEOUT, 1023, maximum stall cycles allowed in S_GRANT or S_WAIT_ACK before the grant is force-released; legal range 1..65535.
CNT_W, 16, width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
req  in  N_REQ  requester i wants the channel; held high for the whole packet.
src_data  in  8*N_REQ  byte from requester i, in bits [8i+7:8i].
src_valid  in  N_REQ  src_data[i] is valid.
src_last  in  N_REQ  the current byte of requester i is the last of its packet.
src_ready  out  N_REQ  byte accepted; a transfer happens when src_valid[i] and src_ready[i] are both high.
grant  out  N_REQ  one-hot or zero; registered owner of the channel.
uart_start  out  1  one-cycle pulse that launches transmission of uart_data.
uart_data  out  8  registered byte presented to the UART; held stable until the next launch.
uart_busy  in  1  UART is transmitting; rises after uart_start and falls when the byte is done.
timeout_err  out  1  one-cycle pulse when a grant is force-released by timeout.

Behaviour:
- Reset, asynchronous: state=S_IDLE, grant=0, src_ready=0, uart_start=0, uart_data=8'h00, timeout_err=0, last_ptr=N_REQ-1 (requester 0 wins first), cnt=0, last_q=0.
- States: S_IDLE, S_GRANT, S_SEND, S_WAIT_ACK, S_WAIT_DONE.
- S_IDLE:
  - If req!=0, pick the first set bit searching circularly from last_ptr+1.
  - Register grant onehot(pick) and last_ptr=pick; go to S_GRANT next cycle. Arbitration latency is one cycle.
- S_GRANT:
  - src_ready[g]=1 combinationally, only for the granted index; all other src_ready bits are 0.
  - On src_valid[g]: latch uart_data<=src_data[g] and last_q<=src_last[g], clear cnt, go to S_SEND.
  - Else if req[g]==0: set grant=0 and go to S_IDLE. No error is flagged; this is a packet abort between bytes.
  - Else increment cnt. When cnt==TIMEOUT: pulse timeout_err, set grant=0, go to S_IDLE.
- S_SEND: uart_start=1 for exactly this cycle; clear cnt; go to S_WAIT_ACK.
- S_WAIT_ACK:
  - If uart_busy=1, go to S_WAIT_DONE.
  - Otherwise increment cnt; when cnt==TIMEOUT, pulse timeout_err, set grant=0, go to S_IDLE.
- S_WAIT_DONE:
  - Wait for uart_busy=0 with no timeout, since UART byte time is bounded.
  - Then, if last_q=1: set grant=0 and go to S_IDLE. Otherwise go to S_GRANT.
- Throughput: at most one byte per UART frame; the arbiter adds 3 overhead cycles per byte.
- Grant lock: while grant!=0, changes on other req bits are ignored. A drop of req[g] is ignored in S_SEND, S_WAIT_ACK and S_WAIT_DONE; it takes effect only on re-entry to S_GRANT.
- Simultaneous requests: resolved purely by round-robin from last_ptr. A requester that just finished has the lowest priority next time.
- Single requester: it may be re-granted back-to-back, with one S_IDLE cycle between packets.
- A requester that asserts src_valid without req is never served.
- src_valid/src_data from ungranted requesters do not affect any output.
- uart_start never asserts while uart_busy=1. Entry to S_GRANT only happens after busy=0 has been observed.
- Reset mid-packet: everything returns to reset values immediately. A byte in flight in the UART is not tracked.

Decomposition:
- Package uart_arb_pkg holds: the state encoding (3-bit localparams S_IDLE..S_WAIT_DONE), the default N_REQ and TIMEOUT, and ASCII_SPACE/ASCII_STAR for shared bench use.
- One sub-module, rr_pick:
  - Combinational round-robin picker.
  - Inputs: req[N_REQ], last_ptr.
  - Outputs: pick index and any_req.
  - Reused by future arbiters.

Test Plan:
- Single packet: req=001, requester 0 sends 8'h2A, 8'h20, 8'h31 (last on 8'h31), UART busy for 10 cycles per byte -> grant=001 one cycle after req; three uart_start pulses with uart_data 2A, 20, 31 in order; grant=000 after the third busy fall.
- Contention: req=111 from reset, each requester sends a 1-byte packet -> grants in order 001, 010, 100. Requester 0 re-requesting after its packet is served after 100.
- Lock: requester 1 is granted mid-packet and req=101 arrives -> no grant change until requester 1's last byte. The next grant is 100 (from last_ptr=1).
- Idle-source timeout with TIMEOUT=8: req=010, src_valid never asserted -> timeout_err pulses at cycle 8 of S_GRANT, grant=000, no uart_start.
- UART no-ack with TIMEOUT=8: uart_busy stuck at 0 after uart_start -> timeout_err after 8 cycles in S_WAIT_ACK and grant released. Abort case: req[g] dropped in S_GRANT -> grant=000 next cycle, no error.
- Async reset asserted during S_WAIT_DONE -> grant, src_ready, uart_start and uart_data immediately 0. After release, requester 0 has priority for req=111.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
// State encoding, default sizing and ASCII constants.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT     = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    localparam int DEF_N_REQ   = 3;
    localparam int DEF_TIMEOUT = 1023;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches circularly starting just after last_ptr.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    last_ptr,
    output logic [PW-1:0]    pick,
    output logic             any_req
);

    always_comb begin
        int idx;
        idx     = 0;
        pick    = '0;
        any_req = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_ptr) + k) % N_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of one UART transmitter.
// Forwards bytes with a start/busy handshake and a stall timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] src_data,
    input  logic [N_REQ-1:0]   src_valid,
    input  logic [N_REQ-1:0]   src_last,
    output logic [N_REQ-1:0]   src_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               uart_start,
    output logic [7:0]         uart_data,
    input  logic               uart_busy,
    output logic               timeout_err
);

    localparam int PW = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [7:0]         data_q, data_d;
    logic               terr_q, terr_d;

    logic [PW-1:0]      pick;
    logic               any_req;
    logic               g_valid;
    logic               g_req;
    logic               g_last;
    logic [7:0]         g_data;
    logic               expired;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req      (req),
        .last_ptr (ptr_q),
        .pick     (pick),
        .any_req  (any_req)
    );

    // ptr_q always names the current owner while a grant is held
    assign g_valid = src_valid[ptr_q];
    assign g_req   = req[ptr_q];
    assign g_last  = src_last[ptr_q];
    assign g_data  = src_data[{ptr_q, 3'b000} +: 8];
    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = '0;
        last_d  = last_q;
        data_d  = data_q;
        terr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d = N_REQ'(1) << pick;
                    ptr_d   = pick;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (g_valid) begin
                    data_d  = g_data;
                    last_d  = g_last;
                    state_d = S_SEND;
                end else if (!g_req) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end else if (expired) begin
                    terr_d  = 1'b1;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (uart_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (expired) begin
                    terr_d  = 1'b1;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GRANT;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(N_REQ - 1);
            cnt_q   <= '0;
            last_q  <= 1'b0;
            data_q  <= 8'h00;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            terr_q  <= terr_d;
        end
    end

    assign src_ready   = (state_q == S_GRANT) ? grant_q : '0;
    assign grant       = grant_q;
    assign uart_start  = (state_q == S_SEND);
    assign uart_data   = data_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// Directed scenarios plus randomized packets.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_ready;
  logic [N-1:0]   grant;
  logic           uart_start;
  logic [7:0]     uart_data;
  logic           uart_busy;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N), .TIMEOUT(TMO), .CNT_W(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .grant       (grant),
    .uart_start  (uart_start),
    .uart_data   (uart_data),
    .uart_busy   (uart_busy),
    .timeout_err (timeout_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic fail(string tag);
    n_fail++;
    $error("FAIL %s", tag);
  endtask

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] data;
  } exp_t;

  logic [8:0]   sbuf [N][64];
  int           shd [N];
  int           stl [N];
  int           mhd [N];
  int           gap [N];
  logic [N-1:0] req_ovr;
  logic [N-1:0] fire;
  logic         no_ack;
  int           ack_cnt, busy_cnt;
  int           ack_lo, ack_hi;
  int           busy_lo, busy_hi, gap_hi;
  int           start_cnt;
  int           m_last;
  exp_t         expq [$];

  task automatic clear_tb();
    for (int i = 0; i < N; i++) begin
      shd[i] = 0; stl[i] = 0;
      mhd[i] = 0; gap[i] = 0;
    end
    expq.delete();
    ack_cnt = 0; busy_cnt = 0;
    uart_busy = 1'b0;
    req_ovr = '0; fire = '0; req = '0;
    src_valid = '0; src_last = '0;
    src_data = '0;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        shd[i]++;
        gap[i] = $urandom_range(0, gap_hi);
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        uart_busy = 1'b1;
        busy_cnt  = $urandom_range(busy_lo, busy_hi);
      end
    end else if (uart_busy) begin
      busy_cnt--;
      if (busy_cnt == 0) uart_busy = 1'b0;
    end
    if (uart_start) begin
      start_cnt++;
      n_assert++;
      if (uart_busy !== 1'b0) fail("busy_at_start");
      n_assert++;
      if (expq.size() == 0) fail("start_expected");
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_assert++;
        if (uart_data !== e.data) fail("start_data");
        n_assert++;
        if (grant !== (N'(1) << e.idx)) fail("start_grant");
      end
      if (!no_ack) ack_cnt = $urandom_range(ack_lo, ack_hi);
    end
    for (int i = 0; i < N; i++) begin
      logic pend;
      logic [8:0] h;
      pend = (shd[i] != stl[i]);
      h = sbuf[i][shd[i] % 64];
      req[i]       = pend | req_ovr[i];
      src_valid[i] = pend && (gap[i] == 0);
      src_last[i]  = h[8];
      src_data[8*i +: 8] = h[7:0];
    end
    fire = src_valid & src_ready;
    n_assert++;
    if ((src_ready & ~grant) !== 3'b000) fail("ready_only_granted");
    n_assert++;
    if ($onehot0(grant) !== 1'b1) fail("grant_onehot0");
  endtask

  task automatic push_byte(int r, logic [7:0] b, logic lst);
    sbuf[r][stl[r] % 64] = {lst, b};
    stl[r]++;
  endtask

  task automatic load_pkt(int r, int len);
    for (int b = 0; b < len; b++)
      push_byte(r, 8'($urandom_range(32, 126)), b == len - 1);
  endtask

  task automatic plan();
    exp_t e;
    logic [8:0] w;
    int jj;
    bit found;
    forever begin
      found = 0;
      jj = 0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (!found && mhd[j] != stl[j]) begin
          found = 1;
          jj = j;
        end
      end
      if (!found) break;
      do begin
        w = sbuf[jj][mhd[jj] % 64];
        mhd[jj]++;
        e.idx  = 8'(jj);
        e.data = w[7:0];
        expq.push_back(e);
      end while (!w[8]);
      m_last = jj;
    end
  endtask

  task automatic run_idle(string tag, int budget);
    int c;
    bit done;
    c = 0;
    done = 0;
    while (c < budget && !done) begin
      tick();
      c++;
      n_assert++;
      if (timeout_err !== 1'b0) fail({tag, "_no_timeout"});
      done = (grant == '0) && !uart_busy &&
             ack_cnt == 0 && expq.size() == 0;
      for (int i = 0; i < N; i++)
        if (shd[i] != stl[i]) done = 0;
    end
    n_assert++;
    if (done !== 1'b1) fail({tag, "_completed"});
  endtask

  task automatic wait_start(string tag, int budget);
    int s, c;
    s = start_cnt;
    c = 0;
    while (c < budget && start_cnt == s) begin
      tick();
      c++;
    end
    n_assert++;
    if (start_cnt == s) fail({tag, "_started"});
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    clear_tb();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    m_last = N - 1;
  endtask

  initial begin
    int s;
    ack_lo = 1; ack_hi = 1;
    busy_lo = 10; busy_hi = 10;
    gap_hi = 0; no_ack = 1'b0;
    start_cnt = 0; m_last = N - 1;
    clear_tb();
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if (grant !== 3'b000) fail("rst_grant");
    n_assert++;
    if (src_ready !== 3'b000) fail("rst_ready");
    n_assert++;
    if (uart_start !== 1'b0) fail("rst_start");
    n_assert++;
    if (uart_data !== 8'h00) fail("rst_data");
    n_assert++;
    if (timeout_err !== 1'b0) fail("rst_terr");
    @(negedge clk) rst_n = 1'b1;

    push_byte(0, ASCII_STAR, 1'b0);
    push_byte(0, ASCII_SPACE, 1'b0);
    push_byte(0, 8'h31, 1'b1);
    plan();
    tick();
    n_assert++;
    if (grant !== 3'b000) fail("arb_before");
    tick();
    n_assert++;
    if (grant !== 3'b001) fail("arb_latency");
    run_idle("single", 300);
    n_assert++;
    if (start_cnt != 3) fail("single_starts");

    do_reset();
    ack_lo = 1; ack_hi = 3;
    busy_lo = 2; busy_hi = 6;
    load_pkt(0, 1); load_pkt(0, 1);
    load_pkt(1, 1); load_pkt(2, 1);
    plan();
    run_idle("contention", 400);

    gap_hi = 2;
    load_pkt(1, 4);
    plan();
    wait_start("lock_first", 100);
    load_pkt(0, 2);
    load_pkt(2, 2);
    plan();
    run_idle("lock", 600);

    s = start_cnt;
    req_ovr = 3'b010;
    tick();
    for (int k = 1; k <= TMO; k++) begin
      tick();
      n_assert++;
      if (grant !== 3'b010) fail("idle_to_grant");
      n_assert++;
      if (timeout_err !== 1'b0) fail("idle_to_early");
    end
    req_ovr = '0;
    tick();
    n_assert++;
    if (grant !== 3'b000) fail("idle_to_release");
    n_assert++;
    if (timeout_err !== 1'b1) fail("idle_to_pulse");
    tick();
    n_assert++;
    if (timeout_err !== 1'b0) fail("idle_to_pulse_end");
    n_assert++;
    if (start_cnt != s) fail("idle_to_no_start");
    m_last = 1;

    no_ack = 1'b1;
    load_pkt(2, 1);
    plan();
    wait_start("noack", 60);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      n_assert++;
      if (grant !== 3'b100) fail("noack_grant");
      n_assert++;
      if (timeout_err !== 1'b0) fail("noack_early");
    end
    tick();
    n_assert++;
    if (grant !== 3'b000) fail("noack_release");
    n_assert++;
    if (timeout_err !== 1'b1) fail("noack_pulse");
    no_ack = 1'b0;
    tick();

    req_ovr = 3'b001;
    tick();
    tick();
    n_assert++;
    if (grant !== 3'b001) fail("abort_grant");
    req_ovr = '0;
    tick();
    tick();
    n_assert++;
    if (grant !== 3'b000) fail("abort_release");
    n_assert++;
    if (timeout_err !== 1'b0) fail("abort_no_err");
    tick();
    n_assert++;
    if (timeout_err !== 1'b0) fail("abort_no_err2");
    m_last = 0;

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++)
          load_pkt(i, $urandom_range(1, 4));
      end
      plan();
      run_idle("random", 3000);
    end

    ack_lo = 1; ack_hi = 1;
    busy_lo = 10; busy_hi = 10;
    load_pkt(1, 2);
    plan();
    wait_start("rst_mid", 100);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (grant !== 3'b000) fail("rst_mid_grant");
    n_assert++;
    if (src_ready !== 3'b000) fail("rst_mid_ready");
    n_assert++;
    if (uart_start !== 1'b0) fail("rst_mid_start");
    n_assert++;
    if (uart_data !== 8'h00) fail("rst_mid_data");
    clear_tb();
    @(negedge clk) rst_n = 1'b1;
    m_last = N - 1;
    ack_lo = 1; ack_hi = 3;
    busy_lo = 2; busy_hi = 6;
    load_pkt(0, 1); load_pkt(1, 1);
    load_pkt(2, 1);
    plan();
    run_idle("post_reset", 400);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
